// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-stage access controller (optional stall counter: MEM_STALL_CNT_EN)
module mem_access_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic                   req_read,
    input  logic                   req_write,
    input  logic                   req_indirect,
    input  logic [15:0]            addr,
    input  logic [15:0]            wdata,
    input  logic [1:0]             byte_en,
    input  logic                   dmem_resp,
    input  logic [15:0]            dmem_rdata,
    output logic                   dmem_read,
    output logic                   dmem_write,
    output logic [15:0]            dmem_addr,
    output logic [15:0]            dmem_wdata,
    output logic [1:0]             dmem_byte_enable,
    output logic                   stall,
    output logic [15:0]            load_data
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PTR    = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e      state_q;
    logic        dmem_read_q;
    logic        dmem_write_q;
    logic        rd_q;
    logic        wr_q;
    logic        ind_q;
    logic [15:1] addr_q;
    logic [15:1] ptr_q;
    logic [15:0] wdata_q;
    logic [1:0]  be_q;
    logic [15:0] load_data_q;

    logic        op_start;
    logic [1:0]  be_eff;
    logic        unused_addr_lsb;

    // Accesses are halfword aligned; the byte lane is carried by byte_en.
    assign unused_addr_lsb = addr[0];

    assign op_start = req_valid & (req_read | req_write);
    assign be_eff   = ind_q ? 2'b11 : be_q;

    // Zero-extend byte loads from the selected lane.
    function automatic logic [15:0] fmt_load(input logic [1:0] be, input logic [15:0] rdata);
        case (be)
            2'b01:   fmt_load = {8'h00, rdata[7:0]};
            2'b10:   fmt_load = {8'h00, rdata[15:8]};
            default: fmt_load = rdata;
        endcase
    endfunction

    // Access sequencer: latches the op at entry so a dropped req_valid cannot orphan a cache transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            ind_q        <= 1'b0;
            addr_q       <= '0;
            ptr_q        <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            load_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_start) begin
                        rd_q    <= req_read;
                        wr_q    <= req_write & ~req_read;
                        ind_q   <= req_indirect;
                        addr_q  <= addr[15:1];
                        be_q    <= byte_en;
                        wdata_q <= (!req_indirect && byte_en == 2'b10) ?
                                   {wdata[7:0], wdata[7:0]} : wdata;
                        if (req_indirect) begin
                            state_q     <= PTR;
                            dmem_read_q <= 1'b1;
                        end else begin
                            state_q      <= ACCESS;
                            dmem_read_q  <= req_read;
                            dmem_write_q <= req_write & ~req_read;
                        end
                    end
                end
                PTR: begin
                    if (dmem_resp) begin
                        ptr_q        <= dmem_rdata[15:1];
                        state_q      <= ACCESS;
                        dmem_read_q  <= rd_q;
                        dmem_write_q <= wr_q;
                    end
                end
                ACCESS: begin
                    if (dmem_resp) begin
                        if (rd_q) begin
                            load_data_q <= fmt_load(be_eff, dmem_rdata);
                        end
                        state_q      <= DONE;
                        dmem_read_q  <= 1'b0;
                        dmem_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Cache address/lanes/data are only meaningful while a strobe is up; zero otherwise.
    always_comb begin
        dmem_addr        = 16'h0000;
        dmem_byte_enable = 2'b00;
        dmem_wdata       = 16'h0000;
        if (state_q == PTR) begin
            dmem_addr        = {addr_q, 1'b0};
            dmem_byte_enable = 2'b11;
        end else if (state_q == ACCESS) begin
            dmem_addr        = ind_q ? {ptr_q, 1'b0} : {addr_q, 1'b0};
            dmem_byte_enable = be_eff;
            dmem_wdata       = wr_q ? wdata_q : 16'h0000;
        end
    end

    assign dmem_read  = dmem_read_q;
    assign dmem_write = dmem_write_q;
    assign load_data  = load_data_q;
    assign stall      = op_start & (state_q != DONE);

`ifdef MEM_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic        req_indirect;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  byte_en;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic        stall;
    logic [15:0] load_data;
`ifdef MEM_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    mem_access_ctrl #(.STALL_CNT_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_read         (req_read),
        .req_write        (req_write),
        .req_indirect     (req_indirect),
        .addr             (addr),
        .wdata            (wdata),
        .byte_en          (byte_en),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .stall            (stall),
        .load_data        (load_data)
`ifdef MEM_STALL_CNT_EN
        ,
        .stall_count      (stall_count)
`endif
    );

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [1:0]  be;
        logic [15:0] wd;
    } acc_t;

    acc_t        acc_q[$];
    logic [15:0] mem [logic [15:0]];
    int          wait_a;
    int          wait_b;
    int          wcnt;
    int          checks;
    int          failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Cache model: answers the Nth strobe cycle, logging what the DUT presented.
    initial begin
        dmem_resp  = 1'b0;
        dmem_rdata = 16'h0000;
        wcnt       = 0;
        forever begin
            @(negedge clk);
            if (rst_n && (dmem_read || dmem_write)) begin
                wcnt++;
                if (wcnt >= ((acc_q.size() == 0) ? wait_a : wait_b)) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = mem.exists(dmem_addr) ? mem[dmem_addr] : 16'h0000;
                    acc_q.push_back('{rd: dmem_read, wr: dmem_write, a: dmem_addr,
                                      be: dmem_byte_enable, wd: dmem_wdata});
                    wcnt = 0;
                end else begin
                    dmem_resp = 1'b0;
                end
            end else begin
                dmem_resp = 1'b0;
                wcnt      = 0;
            end
        end
    end

    task automatic run_op(input string tag, input logic rd, input logic wr, input logic ind,
                          input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be,
                          input int n1, input int n2, input int exp_stall,
                          input logic [15:0] exp_ld);
        int cnt;
        acc_q.delete();
        wait_a = n1;
        wait_b = n2;
        @(negedge clk);
        req_valid    = 1'b1;
        req_read     = rd;
        req_write    = wr;
        req_indirect = ind;
        addr         = a;
        wdata        = wd;
        byte_en      = be;
        #1;
        cnt = 0;
        while (stall && cnt < 100) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check_eq({tag, " stall_cycles"}, cnt, exp_stall);
        check_eq({tag, " load_data"}, load_data, exp_ld);
        req_valid = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
        @(negedge clk);
        #1;
        check_eq({tag, " idle_no_strobe"}, {dmem_read, dmem_write}, 2'b00);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        wait_a       = 1;
        wait_b       = 1;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_read     = 1'b0;
        req_write    = 1'b0;
        req_indirect = 1'b0;
        addr         = 16'h0000;
        wdata        = 16'h0000;
        byte_en      = 2'b11;
        mem[16'h1234] = 16'hBEEF;
        mem[16'h2000] = 16'h3002;
        mem[16'h3002] = 16'h7777;
        mem[16'h0040] = 16'h12F0;

        repeat (2) @(negedge clk);
        #1;
        check_eq("reset strobes", {dmem_read, dmem_write}, 2'b00);
        check_eq("reset stall", stall, 1'b0);
        check_eq("reset load_data", load_data, 16'h0000);
        check_eq("reset dmem_addr", dmem_addr, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // LDR word, 3-cycle cache wait
        run_op("ldr", 1, 0, 0, 16'h1234, 16'h0000, 2'b11, 3, 3, 4, 16'hBEEF);
        check_eq("ldr n_access", acc_q.size(), 1);
        if (acc_q.size() >= 1) begin
            check_eq("ldr rd_wr", {acc_q[0].rd, acc_q[0].wr}, 2'b10);
            check_eq("ldr addr", acc_q[0].a, 16'h1234);
            check_eq("ldr be", acc_q[0].be, 2'b11);
        end

        // LDB high byte, response in the strobe's first cycle
        mem[16'h1234] = 16'hA55A;
        run_op("ldb_hi", 1, 0, 0, 16'h1235, 16'h0000, 2'b10, 1, 1, 2, 16'h00A5);
        if (acc_q.size() >= 1) begin
            check_eq("ldb_hi addr", acc_q[0].a, 16'h1234);
            check_eq("ldb_hi be", acc_q[0].be, 2'b10);
        end

        // STB high byte: data replicated, load_data untouched
        run_op("stb_hi", 0, 1, 0, 16'h0101, 16'h00C3, 2'b10, 2, 2, 3, 16'h00A5);
        if (acc_q.size() >= 1) begin
            check_eq("stb_hi rd_wr", {acc_q[0].rd, acc_q[0].wr}, 2'b01);
            check_eq("stb_hi addr", acc_q[0].a, 16'h0100);
            check_eq("stb_hi be", acc_q[0].be, 2'b10);
            check_eq("stb_hi wdata", acc_q[0].wd, 16'hC3C3);
        end

        // LDI: pointer fetch then data fetch, both waits add
        run_op("ldi", 1, 0, 1, 16'h2000, 16'h0000, 2'b11, 2, 2, 5, 16'h7777);
        check_eq("ldi n_access", acc_q.size(), 2);
        if (acc_q.size() >= 2) begin
            check_eq("ldi ptr addr", acc_q[0].a, 16'h2000);
            check_eq("ldi ptr be", acc_q[0].be, 2'b11);
            check_eq("ldi data addr", acc_q[1].a, 16'h3002);
            check_eq("ldi data rd", acc_q[1].rd, 1'b1);
        end

        // LDB low byte zero-extends
        run_op("ldb_lo", 1, 0, 0, 16'h0041, 16'h0000, 2'b01, 1, 1, 2, 16'h00F0);
        if (acc_q.size() >= 1) begin
            check_eq("ldb_lo be", acc_q[0].be, 2'b01);
        end

        // Read and write both set: read wins
        run_op("rdwr", 1, 1, 0, 16'h0040, 16'hFFFF, 2'b11, 2, 2, 3, 16'h12F0);
        if (acc_q.size() >= 1) begin
            check_eq("rdwr rd_wr", {acc_q[0].rd, acc_q[0].wr}, 2'b10);
        end

        // Async reset during the cache wait
        acc_q.delete();
        wait_a = 50;
        wait_b = 50;
        @(negedge clk);
        req_valid = 1'b1;
        req_read  = 1'b1;
        addr      = 16'h0200;
        byte_en   = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_mid strobe_up", dmem_read, 1'b1);
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_read  = 1'b0;
        #1;
        check_eq("rst_mid dmem_read", dmem_read, 1'b0);
        check_eq("rst_mid stall", stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 1, 0, 0, 16'h0040, 16'h0000, 2'b11, 1, 1, 2, 16'h12F0);

`ifdef MEM_STALL_CNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("scnt reset", stall_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("scnt_a", 1, 0, 0, 16'h1234, 16'h0000, 2'b11, 2, 2, 3, 16'hA55A);
        run_op("scnt_b", 1, 0, 0, 16'h1234, 16'h0000, 2'b11, 2, 2, 3, 16'hA55A);
        check_eq("scnt total", stall_count, 16'd6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage access controller. Sits between the EX/MEM pipeline register, already carrying the byte-lane-adjusted byte enable and regfile select, and the data-cache port.
- Sequences single loads/stores and two-access indirect ops (LDI/STI). Stalls the pipeline until the cache responds, then presents formatted load data to the MEM/WB register.
- LDB/STB byte-lane handling is driven only by the incoming byte enable.

Parameters:
- STALL_CNT_W, 16, width of the optional stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  EX/MEM holds a memory-class instruction this cycle.
- req_read  in  1  load (LDR/LDB/LDI).
- req_write  in  1  store (STR/STB/STI).
- req_indirect  in  1  LDI/STI: first fetch a pointer from addr.
- addr  in  16  effective address.
- wdata  in  16  store data (SR value).
- byte_en  in  2  lane enable: 01 low byte, 10 high byte, 11 word.
- dmem_resp  in  1  cache completion, one-cycle pulse.
- dmem_rdata  in  16  cache read data, valid with dmem_resp.
- dmem_read  out  1  cache read strobe.
- dmem_write  out  1  cache write strobe.
- dmem_addr  out  16  cache address.
- dmem_wdata  out  16  cache write data.
- dmem_byte_enable  out  2  cache lane enables.
- stall  out  1  hold all upstream pipeline registers.
- load_data  out  16  formatted load result for MEM/WB.
- stall_count  out  STALL_CNT_W  stall cycles; only when MEM_STALL_CNT_EN is defined.

Behaviour:
- States: IDLE, PTR (indirect pointer read), ACCESS, DONE. Reset → IDLE asynchronously.
- Reset values:
  - dmem_read = 0, dmem_write = 0, stall = 0.
  - load_data = 0, ptr register = 0, stall_count = 0.
  - dmem_addr, dmem_wdata and dmem_byte_enable are don't-care while no strobe is active. Drive 0.
- IDLE, on req_valid & (req_read | req_write):
  - req_indirect = 1 → PTR.
  - Otherwise → ACCESS.
  - No cache strobe is issued in the entry cycle.
- PTR:
  - dmem_read = 1, dmem_addr = {addr[15:1],0}, dmem_byte_enable = 11.
  - On dmem_resp: latch ptr = dmem_rdata, → ACCESS.
- ACCESS:
  - Address: ptr if indirect, else addr. Bit 0 is forced to 0.
  - dmem_read = req_read, dmem_write = req_write.
  - dmem_byte_enable = byte_en for non-indirect ops, 11 for LDI/STI.
  - dmem_wdata: byte_en 10 → {wdata[7:0], wdata[7:0]}. Otherwise wdata.
  - On dmem_resp: register load_data, → DONE.
- load_data formatting:
  - byte_en 01 → {8'h00, rdata[7:0]}.
  - byte_en 10 → {8'h00, rdata[15:8]}.
  - Otherwise → rdata.
  - Load data is zero-extended, per LC-3b LDB.
  - Stores leave load_data unchanged.
- DONE: stall = 0 for exactly one cycle; the pipeline advances on that edge. → IDLE.
- stall = req_valid & (req_read | req_write) & (state != DONE). It is combinational, so it rises in the same cycle the op arrives.
- Latency:
  - Single access: 1 (entry) + N (cache wait, N ≥ 1) + 1 (DONE).
  - Indirect: the two cache waits add.
- Boundary cases:
  - dmem_resp in IDLE/DONE is ignored.
  - dmem_resp in the same cycle a strobe first asserts is accepted.
  - req_valid dropping mid-access: FSM still waits for dmem_resp to avoid an orphan cache transaction, then → DONE → IDLE.
  - req_read & req_write both set: treated as a read.
  - Back-to-back memory ops: DONE → IDLE → new entry. There is no overlap.
  - Async reset mid-access: strobes drop immediately and the FSM is in IDLE. The cache is reset with the same rst_n.

Optional Feature:
- Macro: MEM_STALL_CNT_EN.
- When defined:
  - stall_count port exists.
  - It increments every cycle stall = 1 and saturates at all-ones.
  - It clears only on reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- LDR addr=0x1234, cache rdata=0xBEEF after 3-cycle wait, byte_en 11 → stall high 4 cycles, dmem_addr=0x1234, load_data=0xBEEF in DONE.
- LDB addr=0x1235, byte_en 10, rdata=0xA55A → dmem_byte_enable=10, dmem_addr=0x1234, load_data=0x00A5.
- STB addr=0x0101, wdata=0x00C3, byte_en 10 → dmem_write=1, dmem_wdata=0xC3C3, dmem_byte_enable=10, load_data unchanged.
- LDI addr=0x2000, mem[0x2000]=0x3002, mem[0x3002]=0x7777 → PTR read at 0x2000, then ACCESS read at 0x3002, load_data=0x7777, stall spans both waits.
- rst_n pulled low during ACCESS wait → dmem_read drops the same cycle, stall=0. After release, a new LDR completes normally.
- With MEM_STALL_CNT_EN: two LDRs each with a 2-cycle cache wait → stall_count=6 (3 stall cycles each).
